// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the signed shift-add multiplier controller.
//   state_t : controller state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   OP_W    : default operand width (two's complement)
//   MAG_W   : operand magnitude width (|-2^(OP_W-1)| still fits unsigned)
//   PROD_W  : product magnitude / accumulator width
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int MAG_W  = OP_W;
  localparam int PROD_W = 2*OP_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_shift_add_dp.sv
// mult_shift_add_dp: shift-add datapath for the sequential multiplier.
//   clock, reset_n : clock / async active-low reset
//   load           : convert a_raw/b_raw to magnitudes, clear accumulator
//   step           : one partial product (add if multiplier LSB set, shift)
//   a_raw, b_raw   : two's-complement operands (sampled on load)
//   mplr_zero      : remaining multiplier bits are all zero
//   acc            : accumulated product magnitude
module mult_shift_add_dp #(
  parameter int MAG_W  = mult_pkg::MAG_W,
  parameter int PROD_W = mult_pkg::PROD_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [MAG_W-1:0]  a_raw,
  input  logic [MAG_W-1:0]  b_raw,
  output logic              mplr_zero,
  output logic [PROD_W-1:0] acc
);

  logic [PROD_W-1:0] mcand_reg;
  logic [MAG_W-1:0]  mplr_reg;
  logic [MAG_W-1:0]  a_mag, b_mag;

  // Magnitude kept in MAG_W unsigned bits: the most negative value maps to
  // 2^(MAG_W-1), which is representable, so no overflow case exists.
  assign a_mag = a_raw[MAG_W-1] ? (~a_raw + MAG_W'(1)) : a_raw;
  assign b_mag = b_raw[MAG_W-1] ? (~b_raw + MAG_W'(1)) : b_raw;

  assign mplr_zero = (mplr_reg == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_reg <= '0;
      mplr_reg  <= '0;
      acc       <= '0;
    end else if (load) begin
      mcand_reg <= {{(PROD_W-MAG_W){1'b0}}, a_mag};
      mplr_reg  <= b_mag;
      acc       <= '0;
    end else if (step) begin
      if (mplr_reg[0]) acc <= acc + mcand_reg;
      mplr_reg  <= mplr_reg >> 1;
      // The final shift may push a bit off the top; by then no bits of the
      // multiplier remain, so that partial product is never added.
      mcand_reg <= mcand_reg << 1;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencing controller for a signed OP_W x OP_W shift-add
// multiplier with valid/ready handshakes on both sides.
//   clock, reset_n           : clock / async active-low reset
//   in_valid, in_ready       : operand-pair handshake (ready only in IDLE)
//   multiplicand, multiplier : signed operands A, B
//   abort                    : synchronous cancel of an in-flight operation
//   out_valid, out_ready     : result handshake (valid only in DONE)
//   result_mag               : product magnitude
//   sign                     : product negative (never set for a zero product)
//   zflag                    : product is zero
//   product                  : signed two's-complement product
//   busy                     : controller not IDLE
// Latency from acceptance is 2 + n cycles, n = position of |B|'s top set bit
// plus one (0 for B == 0); the loop stops early once the multiplier empties.
module mult_seq_ctrl #(
  parameter int OP_W = mult_pkg::OP_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   multiplicand,
  input  logic [OP_W-1:0]   multiplier,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-2:0] result_mag,
  output logic              sign,
  output logic              zflag,
  output logic [2*OP_W-1:0] product,
  output logic              busy
);

  import mult_pkg::*;

  localparam int PW = 2*OP_W - 1;

  state_t          state;
  logic [OP_W-1:0] a_reg, b_reg;
  logic            sign_raw;
  logic            load, step, mplr_zero;
  logic [PW-1:0]   acc;
  logic            acc_zero, neg;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Abort wins over datapath activity so a cancelled op leaves nothing behind.
  assign load = (state == LOAD) && !abort;
  assign step = (state == RUN) && !mplr_zero && !abort;

  assign acc_zero = (acc == '0);
  assign neg      = sign_raw && !acc_zero;

  mult_shift_add_dp #(
    .MAG_W  (OP_W),
    .PROD_W (PW)
  ) u_dp (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .a_raw     (a_reg),
    .b_raw     (b_reg),
    .mplr_zero (mplr_zero),
    .acc       (acc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sign_raw   <= 1'b0;
      result_mag <= '0;
      sign       <= 1'b0;
      zflag      <= 1'b0;
      product    <= '0;
    end else begin
      case (state)
        // abort is a no-op here; a simultaneous in_valid is still accepted.
        IDLE: begin
          if (in_valid) begin
            a_reg    <= multiplicand;
            b_reg    <= multiplier;
            sign_raw <= multiplicand[OP_W-1] ^ multiplier[OP_W-1];
            state    <= LOAD;
          end
        end
        LOAD: state <= abort ? IDLE : RUN;
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (mplr_zero) begin
            result_mag <= acc;
            zflag      <= acc_zero;
            sign       <= neg;
            product    <= neg ? -{1'b0, acc} : {1'b0, acc};
            state      <= DONE;
          end
        end
        DONE: if (abort || out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  localparam int OP_W = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b1;
  logic [OP_W-1:0]   multiplicand = '0;
  logic [OP_W-1:0]   multiplier = '0;
  logic              in_ready, out_valid, sign, zflag, busy;
  logic [2*OP_W-2:0] result_mag;
  logic [2*OP_W-1:0] product;

  mult_seq_ctrl #(.OP_W(OP_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .abort        (abort),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_mag   (result_mag),
    .sign         (sign),
    .zflag        (zflag),
    .product      (product),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          mag;
    bit          sgn;
    bit          z;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[7];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    int   p, mb;
    p = int'($signed(a)) * int'($signed(b));
    v.a = a;
    v.b = b;
    v.mag = (p < 0) ? -p : p;
    v.sgn = (p < 0);
    v.z = (p == 0);
    v.prod = p[15:0];
    mb = ($signed(b) < 0) ? -int'($signed(b)) : int'($signed(b));
    v.lat = 2;
    while (mb != 0) begin
      v.lat++;
      mb = mb >> 1;
    end
    return v;
  endfunction

  // Called #1 after a clock edge; returns #1 after the acceptance edge.
  task automatic send(input vec_t e, input bit with_abort);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    multiplicand = e.a;
    multiplier   = e.b;
    in_valid     = 1'b1;
    abort        = with_abort;
    sb_q.push_back(e);
    @(posedge clock); #1;
    in_valid     = 1'b0;
    abort        = 1'b0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
  endtask

  task automatic get_result(input string tag);
    int   lat;
    vec_t e;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(e.lat));
    check({tag, " result_mag"}, 32'(result_mag), 32'(e.mag));
    check({tag, " sign"}, 32'(sign), 32'(e.sgn));
    check({tag, " zflag"}, 32'(zflag), 32'(e.z));
    check({tag, " product"}, 32'(product), 32'(e.prod));
  endtask

  // With out_ready high, DONE lasts one cycle and IDLE follows.
  task automatic finish_handshake(input string tag);
    @(posedge clock); #1;
    check({tag, " out_valid_one_cycle"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [14:0] prev_mag;
    int          seen;
    vec_t        v;

    tbl[0] = '{8'd5,    8'hFD, 15,    1'b1, 1'b0, 16'hFFF1, 4};
    tbl[1] = '{8'hF9,   8'd0,  0,     1'b0, 1'b1, 16'h0000, 2};
    tbl[2] = '{8'h80,   8'h80, 16384, 1'b0, 1'b0, 16'h4000, 10};
    tbl[3] = '{8'd0,    8'hFB, 0,     1'b0, 1'b1, 16'h0000, 5};
    tbl[4] = '{8'd127,  8'h80, 16256, 1'b1, 1'b0, 16'hC080, 10};
    tbl[5] = '{8'hFF,   8'd1,  1,     1'b1, 1'b0, 16'hFFFF, 3};
    tbl[6] = '{8'd12,   8'd10, 120,   1'b0, 1'b0, 16'h0078, 6};

    // Reset state
    #2 reset_n = 1'b0;
    #3;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result_mag", 32'(result_mag), 32'd0);
    check("rst product", 32'(product), 32'd0);
    check("rst sign", 32'(sign), 32'd0);
    check("rst zflag", 32'(zflag), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      send(tbl[i], 1'b0);
      get_result($sformatf("tbl%0d", i));
      finish_handshake($sformatf("tbl%0d", i));
    end

    // Random operands against the integer model
    for (int i = 0; i < 8; i++) begin
      v = model(8'($urandom), 8'($urandom));
      send(v, 1'b0);
      get_result($sformatf("rnd%0d", i));
      finish_handshake($sformatf("rnd%0d", i));
    end

    // abort together with in_valid in IDLE: pair is still accepted
    send(model(8'hFA, 8'd9), 1'b1);
    check("idle_abort busy", 32'(busy), 32'd1);
    get_result("idle_abort");
    finish_handshake("idle_abort");

    // Result held while consumer stalls; new operands ignored
    out_ready = 1'b0;
    send(model(8'd12, 8'd10), 1'b0);
    get_result("hold");
    for (int k = 0; k < 5; k++) begin
      in_valid     = k[0];
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      @(posedge clock); #1;
      check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d result_mag", k), 32'(result_mag), 32'd120);
      check($sformatf("hold%0d sign", k), 32'(sign), 32'd0);
      check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("hold release in_ready", 32'(in_ready), 32'd1);
    check("hold release out_valid", 32'(out_valid), 32'd0);
    check("hold release keeps mag", 32'(result_mag), 32'd120);

    // abort on the 2nd RUN cycle
    prev_mag = result_mag;
    send(model(8'd3, 8'd127), 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    abort = 1'b1;
    check("abort busy_before", 32'(busy), 32'd1);
    @(posedge clock); #1;
    abort = 1'b0;
    sb_q.delete();
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) seen++;
      @(posedge clock); #1;
    end
    check("abort no_out_valid", 32'(seen), 32'd0);
    check("abort keeps mag", 32'(result_mag), 32'(prev_mag));
    send(model(8'd2, 8'd2), 1'b0);
    get_result("after_abort");
    finish_handshake("after_abort");

    // reset mid-RUN
    send(model(8'd100, 8'd100), 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst result_mag", 32'(result_mag), 32'd0);
    check("midrst product", 32'(product), 32'd0);
    check("midrst sign_zflag", {30'd0, sign, zflag}, 32'd0);
    #2 reset_n = 1'b1;
    sb_q.delete();
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      if (out_valid) seen++;
    end
    check("midrst no_out_valid", 32'(seen), 32'd0);
    check("midrst in_ready_after", 32'(in_ready), 32'd1);
    send(model(8'hF3, 8'd11), 1'b0);
    get_result("after_rst");
    finish_handshake("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
